// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input between
// consecutive rising edges, with a byte-wide register bus, status flags and IRQ.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PWrite,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  input  logic       PWM_IN,
  output logic       IRQ
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_PER_L  = 8'h02;
  localparam logic [7:0] ADDR_PER_H  = 8'h03;
  localparam logic [7:0] ADDR_HIGH_L = 8'h04;
  localparam logic [7:0] ADDR_HIGH_H = 8'h05;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic at_limit(input logic [CNT_W-1:0] v);
    return &v;
  endfunction

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return v + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_p1;
  logic                   rise;

  logic                   wr;
  logic                   rd;
  logic                   ctrl_wr;
  logic                   status_wr;
  logic                   en_clear;
  logic                   en;
  logic                   irq_en;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       period;
  logic [CNT_W-1:0]       high;
  logic                   cap;
  logic                   tmo;

  logic [2:0]             status;
  logic [2:0]             status_set;
  logic [2:0]             status_clr;

  logic [15:0]            period_ext;
  logic [15:0]            high_ext;
  logic [7:0]             period_shadow;
  logic [7:0]             high_shadow;
  logic                   unused_wdata;

  // ---- input synchroniser and rising-edge detect ----
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      sync_p0 <= '0;
      s_p1    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], PWM_IN};
      s_p1    <= s;
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_p1;

  // ---- bus decode and control register ----
  assign wr           = PSEL & PWrite;
  assign rd           = PSEL & ~PWrite;
  assign ctrl_wr      = wr && (PADDR == ADDR_CTRL);
  assign status_wr    = wr && (PADDR == ADDR_STATUS);
  assign en_clear     = ctrl_wr & ~PWDATA[0];
  assign unused_wdata = ^PWDATA[7:3];

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      en     <= PWDATA[0];
      irq_en <= PWDATA[1];
    end
  end

  // ---- measurement events; a disabling write overrides everything ----
  always_comb begin
    cap = 1'b0;
    tmo = 1'b0;
    if (!en_clear) begin
      case (state)
        WAIT_RISE: tmo = ~rise & at_limit(cnt);
        MEASURE: begin
          cap = rise;
          tmo = ~rise & at_limit(cnt);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      hcnt  <= '0;
    end else if (en_clear) begin
      state <= IDLE;
      cnt   <= '0;
      hcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          hcnt <= '0;
          if (en) state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_ONE;
            hcnt  <= CNT_ONE;
          end else if (tmo) begin
            cnt <= '0;
          end else begin
            cnt <= inc(cnt);
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt  <= CNT_ONE;
            hcnt <= CNT_ONE;
          end else if (tmo) begin
            state <= WAIT_RISE;
            cnt   <= '0;
            hcnt  <= '0;
          end else begin
            cnt <= inc(cnt);
            if (s) hcnt <= inc(hcnt);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          hcnt  <= '0;
        end
      endcase
    end
  end

  // ---- capture registers ----
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      period <= '0;
      high   <= '0;
    end else if (cap) begin
      period <= cnt;
      high   <= hcnt;
    end
  end

  // Hardware set wins over a simultaneous write-one-to-clear.
  assign status_set = {tmo, cap & status[0], cap};
  assign status_clr = status_wr ? PWDATA[2:0] : 3'b000;

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      status <= 3'b000;
      IRQ    <= 1'b0;
    end else begin
      status <= (status & ~status_clr) | status_set;
      IRQ    <= irq_en & (status[0] | status[2]);
    end
  end

  // ---- registered read port with low/high snapshot ----
  assign period_ext = 16'(period);
  assign high_ext   = 16'(high);

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      PRDATA        <= 8'h00;
      period_shadow <= 8'h00;
      high_shadow   <= 8'h00;
    end else if (rd) begin
      case (PADDR)
        ADDR_CTRL:   PRDATA <= {6'b0, irq_en, en};
        ADDR_STATUS: PRDATA <= {5'b0, status};
        ADDR_PER_L: begin
          PRDATA        <= period_ext[7:0];
          period_shadow <= period_ext[15:8];
        end
        ADDR_PER_H:  PRDATA <= period_shadow;
        ADDR_HIGH_L: begin
          PRDATA      <= high_ext[7:0];
          high_shadow <= high_ext[15:8];
        end
        ADDR_HIGH_H: PRDATA <= high_shadow;
        default:     PRDATA <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed register/timing scenarios, then random PWM periods
// scored against the driven waveform through a queue and an IRQ-driven monitor.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int CNT_W = 9;
  localparam int SYNC  = 2;
  localparam int NRAND = 14;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h01;
  localparam logic [7:0] A_PER_L  = 8'h02;
  localparam logic [7:0] A_PER_H  = 8'h03;
  localparam logic [7:0] A_HIGH_L = 8'h04;
  localparam logic [7:0] A_HIGH_H = 8'h05;

  logic       PCLK    = 1'b0;
  logic       PRESETn = 1'b0;
  logic       PSEL    = 1'b0;
  logic       PWrite  = 1'b0;
  logic [7:0] PADDR   = 8'h00;
  logic [7:0] PWDATA  = 8'h00;
  logic [7:0] PRDATA;
  logic       PWM_IN  = 1'b0;
  logic       IRQ;

  int passed = 0;
  int total  = 0;

  typedef struct {int n; int h;} cap_t;
  cap_t exp_q[$];

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PWrite(PWrite), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PWM_IN(PWM_IN), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWrite = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PSEL = 1'b0; PWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWrite = 1'b0; PADDR = a;
    @(negedge PCLK);
    PSEL = 1'b0;
    d = PRDATA;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input int exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(name, int'(d), exp);
  endtask

  // One PWM period: high for h cycles then low, n cycles in total.
  task automatic drive_period(input int h, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      PWM_IN = (i < h);
    end
  endtask

  task automatic restart(input logic [7:0] ctrl);
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STATUS, 8'h07);
    bus_write(A_CTRL, ctrl);
  endtask

  task automatic stim_proc();
    int n;
    int h;
    int n_prev;
    int h_prev;
    n_prev = 0;
    h_prev = 0;
    for (int i = 0; i < NRAND; i++) begin
      n = int'($urandom_range(60, 20));
      h = int'($urandom_range(n - 1, 1));
      if (i > 0) exp_q.push_back('{n_prev, h_prev});
      drive_period(h, n);
      n_prev = n;
      h_prev = h;
    end
  endtask

  task automatic monitor_proc(input int ncap);
    int waited;
    cap_t e;
    logic [7:0] st, pl, ph, hl, hh;
    for (int i = 0; i < ncap; i++) begin
      waited = 0;
      while (IRQ !== 1'b1 && waited < 200) begin
        @(negedge PCLK);
        waited++;
      end
      chk("rnd_irq_wait", int'(IRQ === 1'b1), 1);
      if (IRQ !== 1'b1) return;
      bus_read(A_STATUS, st);
      bus_read(A_PER_L, pl);
      bus_read(A_PER_H, ph);
      bus_read(A_HIGH_L, hl);
      bus_read(A_HIGH_H, hh);
      chk("rnd_queue_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("rnd_status", int'(st), 1);
      chk("rnd_period", int'({ph, pl}), e.n);
      chk("rnd_high", int'({hh, hl}), e.h);
      bus_write(A_STATUS, 8'h07);
      wait_cyc(2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run incomplete at %0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    #2 PRESETn = 1'b1;
    wait_cyc(3);
    PRESETn = 1'b0;
    chk("rst_prdata", int'(PRDATA), 0);
    chk("rst_irq", int'(IRQ), 0);
    rd_chk("rst_per_h_shadow", A_PER_H, 0);
    rd_chk("rst_ctrl", A_CTRL, 0);
    rd_chk("rst_status", A_STATUS, 0);
    rd_chk("rst_per_l", A_PER_L, 0);
    rd_chk("rst_high_l", A_HIGH_L, 0);
    rd_chk("rst_high_h", A_HIGH_H, 0);

    bus_write(A_CTRL, 8'hFF);
    rd_chk("ctrl_rw", A_CTRL, 8'h03);
    bus_write(A_CTRL, 8'h00);
    bus_write(8'h09, 8'hFF);
    rd_chk("unmapped_write", A_CTRL, 8'h00);
    rd_chk("unmapped_read", 8'h06, 8'h00);

    // duty 5 / period 10, three rises -> two captures -> overrun
    restart(8'h01);
    repeat (3) drive_period(5, 10);
    wait_cyc(4);
    rd_chk("t1_status", A_STATUS, 8'h03);
    rd_chk("t1_per_l", A_PER_L, 10);
    rd_chk("t1_per_h", A_PER_H, 0);
    rd_chk("t1_high_l", A_HIGH_L, 5);
    rd_chk("t1_high_h", A_HIGH_H, 0);
    chk("t1_irq_masked", int'(IRQ), 0);
    bus_write(A_STATUS, 8'h03);
    rd_chk("t1_status_w1c", A_STATUS, 8'h00);

    for (int d = 1; d < 10; d++) begin
      restart(8'h01);
      drive_period(d, 10);
      drive_period(d, 10);
      wait_cyc(4);
      rd_chk($sformatf("sweep%0d_high", d), A_HIGH_L, d);
      rd_chk($sformatf("sweep%0d_per", d), A_PER_L, 10);
      rd_chk($sformatf("sweep%0d_status", d), A_STATUS, 8'h01);
    end

    // W1C of VALID lands on the same edge as a new capture
    restart(8'h01);
    drive_period(5, 20);
    drive_period(5, 20);
    @(negedge PCLK); PWM_IN = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK); PSEL = 1'b1; PWrite = 1'b1; PADDR = A_STATUS; PWDATA = 8'h01;
    @(negedge PCLK); PSEL = 1'b0; PWrite = 1'b0;
    wait_cyc(3);
    PWM_IN = 1'b0;
    rd_chk("t2_set_wins", A_STATUS, 8'h03);
    rd_chk("t2_per_l", A_PER_L, 20);

    // constant low -> timeout only, captures kept
    restart(8'h01);
    wait_cyc(495);
    rd_chk("tlow_before", A_STATUS, 8'h00);
    wait_cyc(20);
    rd_chk("tlow_timeout", A_STATUS, 8'h04);
    rd_chk("tlow_per_kept", A_PER_L, 20);

    // constant high, IRQ masked then unmasked
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STATUS, 8'h07);
    PWM_IN = 1'b1;
    wait_cyc(4);
    bus_write(A_CTRL, 8'h01);
    wait_cyc(495);
    rd_chk("thigh_before", A_STATUS, 8'h00);
    wait_cyc(20);
    rd_chk("thigh_timeout", A_STATUS, 8'h04);
    chk("thigh_irq_masked", int'(IRQ), 0);
    rd_chk("thigh_high_kept", A_HIGH_L, 5);
    bus_write(A_CTRL, 8'h03);
    wait_cyc(2);
    chk("thigh_irq_on", int'(IRQ), 1);
    bus_write(A_CTRL, 8'h00);
    wait_cyc(2);
    chk("thigh_irq_off", int'(IRQ), 0);
    PWM_IN = 1'b0;
    wait_cyc(3);

    // atomic high-byte read across a capture change
    restart(8'h01);
    fork
      begin
        drive_period(200, 300);
        drive_period(100, 160);
        drive_period(1, 4);
      end
      begin
        wait_cyc(320);
        rd_chk("t4_per_l_a", A_PER_L, 8'h2C);
        rd_chk("t4_high_l_a", A_HIGH_L, 8'hC8);
        rd_chk("t4_high_h_a", A_HIGH_H, 8'h00);
      end
    join
    wait_cyc(4);
    rd_chk("t4_per_h_shadow", A_PER_H, 8'h01);
    rd_chk("t4_per_l_b", A_PER_L, 8'hA0);
    rd_chk("t4_per_h_b", A_PER_H, 8'h00);
    rd_chk("t4_high_l_b", A_HIGH_L, 8'h64);
    rd_chk("t4_high_h_b", A_HIGH_H, 8'h00);

    // disable mid-period: two fresh rises needed before a capture
    restart(8'h01);
    drive_period(5, 12);
    bus_write(A_CTRL, 8'h00);
    bus_write(A_CTRL, 8'h01);
    wait_cyc(3);
    fork
      drive_period(4, 30);
      begin
        wait_cyc(20);
        rd_chk("t5_no_capture", A_STATUS, 8'h00);
      end
    join
    drive_period(4, 15);
    wait_cyc(2);
    rd_chk("t5_status", A_STATUS, 8'h01);
    rd_chk("t5_per", A_PER_L, 30);
    rd_chk("t5_high", A_HIGH_L, 4);

    // asynchronous reset in the middle of a measurement
    bus_write(A_CTRL, 8'h03);
    wait_cyc(2);
    chk("t6_irq_before", int'(IRQ), 1);
    rd_chk("t6_prdata_before", A_PER_L, 30);
    drive_period(3, 10);
    @(negedge PCLK);
    #3 PRESETn = 1'b1;
    #1;
    chk("t6_prdata_rst", int'(PRDATA), 0);
    chk("t6_irq_rst", int'(IRQ), 0);
    #20;
    @(negedge PCLK);
    PRESETn = 1'b0;
    rd_chk("t6_per_h", A_PER_H, 0);
    rd_chk("t6_ctrl", A_CTRL, 0);
    rd_chk("t6_status", A_STATUS, 0);
    rd_chk("t6_per_l", A_PER_L, 0);
    rd_chk("t6_high_l", A_HIGH_L, 0);
    rd_chk("t6_high_h", A_HIGH_H, 0);
    bus_write(A_CTRL, 8'h01);
    drive_period(6, 25);
    drive_period(6, 25);
    wait_cyc(2);
    rd_chk("t6_recover_per", A_PER_L, 25);
    rd_chk("t6_recover_high", A_HIGH_L, 6);

    // random periods: stimulus pushes expectations, monitor pops on IRQ
    restart(8'h03);
    wait_cyc(3);
    fork
      stim_proc();
      monitor_proc(NRAND - 1);
    join
    chk("rnd_queue_drained", exp_q.size(), 0);
    bus_write(A_CTRL, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
